// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index width and the hazard controller state encoding.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MISS   = 2'd1,
        LDUSE  = 2'd2,
        HALTED = 2'd3
    } hazard_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous active-high clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge CLK) begin
        if (nRST) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard controller: latch enables/flushes, halt tracking and stall/flush counters.
//
// state  | meaning
// -------+-------------------------------------------------------------
// RUN    | normal flow, all hazard conditions evaluated
// MISS   | data-cache miss outstanding, lower pipeline frozen
// LDUSE  | one-cycle load-use bubble issued; suppresses re-detection
// HALTED | halt reached memory stage; frozen until reset
module hazard_control
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmemREN,
    input  logic             dmemWEN,
    input  logic             ex_load,
    input  regbits_t         ex_wsel,
    input  regbits_t         id_rs,
    input  regbits_t         id_rt,
    input  logic             id_uses_rt,
    input  logic             branch_taken,
    input  logic             mem_halt,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             em_flush,
    output logic             mw_flush,
    output logic             data_stall,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hazard_state_t state, state_next;
    logic          load_use;
    logic          branch_fire;
    logic          stall_inc;

    assign data_stall = (dmemREN | dmemWEN) & ~dhit;

    assign load_use = ex_load && (ex_wsel != '0) &&
                      ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = RUN;
        pc_en       = 1'b1;
        fd_en       = 1'b1;
        de_en       = 1'b1;
        em_en       = 1'b1;
        mw_en       = 1'b1;
        fd_flush    = 1'b0;
        de_flush    = 1'b0;
        em_flush    = 1'b0;
        mw_flush    = 1'b0;
        halt        = 1'b0;
        branch_fire = 1'b0;

        if (nRST) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_en    = 1'b0;
            em_en    = 1'b0;
            mw_en    = 1'b0;
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_flush = 1'b1;
            mw_flush = 1'b1;
        end else if ((state == HALTED) || (mem_halt && !data_stall)) begin
            // A halt still waiting on its own data access is treated as a miss first.
            pc_en      = 1'b0;
            fd_en      = 1'b0;
            de_en      = 1'b0;
            em_en      = 1'b0;
            mw_en      = 1'b0;
            mw_flush   = 1'b1;
            halt       = 1'b1;
            state_next = HALTED;
        end else if (data_stall) begin
            pc_en      = 1'b0;
            fd_en      = 1'b0;
            de_en      = 1'b0;
            em_en      = 1'b0;
            mw_flush   = 1'b1;
            state_next = MISS;
        end else if (branch_taken) begin
            // pc_en stays high even on an I-miss so the redirect target is captured.
            fd_flush    = 1'b1;
            de_flush    = 1'b1;
            branch_fire = 1'b1;
        end else if (load_use && (state != LDUSE)) begin
            pc_en      = 1'b0;
            fd_en      = 1'b0;
            de_flush   = 1'b1;
            state_next = LDUSE;
        end else if (!ihit) begin
            pc_en    = 1'b0;
            fd_flush = 1'b1;
        end
    end

    assign stall_inc = !pc_en && (state != HALTED);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (branch_fire),
        .count (flush_cnt)
    );

endmodule
